// File: rtl/risc_pkg.sv
// Shared definitions for the RISC write-back controller and its helpers.
// Contents:
//   DW, AW, RW - default data, address and register-index widths
//   state_t    - write-back controller state encoding (2-bit)
package risc_pkg;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int RW = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

endpackage

// File: rtl/risc_wb_ctrl_if.sv
// Data-memory request/acknowledge bus.
// Signals:
//   dm_req   - memory request, held until ack or abort
//   dm_we    - 1 = write, 0 = read
//   dm_addr  - memory address
//   dm_wdata - write data
//   dm_ack   - memory completion
//   dm_rdata - read data, valid with dm_ack
// Modports: master (controller side), slave (memory side).
interface risc_wb_ctrl_if #(
    parameter int AW = risc_pkg::AW,
    parameter int DW = risc_pkg::DW
);

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ack, dm_rdata
    );

endinterface

// File: rtl/risc_ack_timer.sv
// Acknowledge timeout counter for a req/ack handshake.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   i_clr      - hold the count at zero (no request outstanding)
//   i_en       - one more cycle waited without ack
//   o_expire   - this waited cycle brings the count to TIMEOUT
module risc_ack_timer #(
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TW-1:0] LP_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Flag is raised on the waited cycle whose increment reaches TIMEOUT, so
    // the owner aborts after exactly TIMEOUT unacknowledged cycles.
    assign o_expire = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/risc_wb_ctrl.sv
// Write-back controller between the execution unit and the register file.
// ALU results commit the cycle after acceptance; loads and stores go through
// the data-memory req/ack bus with an ack timeout, stalling the execution unit
// while outstanding.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   ex_*               - completed instruction from the execution unit
//   ex_stall           - execution unit must hold (combinational from state)
//   dm                 - data-memory bus (master side)
//   reg_wr_vld         - register-file write strobe
//   load_op            - selects dst/dmdataout (1) or dst_o/rslt (0)
//   rslt, dst_o        - ALU write data / destination
//   dst, dmdataout     - load write destination / data
//   mem_err            - one-cycle pulse on memory timeout
module risc_wb_ctrl import risc_pkg::*; #(
    parameter int DW      = risc_pkg::DW,
    parameter int AW      = risc_pkg::AW,
    parameter int RW      = risc_pkg::RW,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_vld,
    input  logic                ex_load,
    input  logic                ex_store,
    input  logic [DW-1:0]       ex_rslt,
    input  logic [RW-1:0]       ex_dst,
    input  logic [AW-1:0]       ex_addr,
    input  logic [DW-1:0]       ex_sdata,
    output logic                ex_stall,
    risc_wb_ctrl_if.master      dm,
    output logic                reg_wr_vld,
    output logic                load_op,
    output logic [DW-1:0]       rslt,
    output logic [RW-1:0]       dst_o,
    output logic [RW-1:0]       dst,
    output logic [DW-1:0]       dmdataout,
    output logic                mem_err
);

    state_t        r_state;
    logic          r_dm_req;
    logic          r_dm_we;
    logic [AW-1:0] r_dm_addr;
    logic [DW-1:0] r_dm_wdata;
    logic [RW-1:0] r_ld_dst;
    logic          r_reg_wr_vld;
    logic          r_load_op;
    logic [DW-1:0] r_rslt;
    logic [RW-1:0] r_dst_o;
    logic [RW-1:0] r_dst;
    logic [DW-1:0] r_dmdataout;
    logic          r_mem_err;

    logic w_tmr_clr;
    logic w_tmr_en;
    logic w_expire;

    // Counter sits at zero outside REQ, which also clears it on entry to REQ.
    assign w_tmr_clr = (r_state != ST_REQ);
    assign w_tmr_en  = (r_state == ST_REQ) && !dm.dm_ack;

    risc_ack_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_ack_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, data included, is reset so no output can
        // show X after reset; there is no storage array here to exempt.
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_dm_req     <= 1'b0;
            r_dm_we      <= 1'b0;
            r_dm_addr    <= '0;
            r_dm_wdata   <= '0;
            r_ld_dst     <= '0;
            r_reg_wr_vld <= 1'b0;
            r_load_op    <= 1'b0;
            r_rslt       <= '0;
            r_dst_o      <= '0;
            r_dst        <= '0;
            r_dmdataout  <= '0;
            r_mem_err    <= 1'b0;
        end else begin
            // NOTE: strobes default low each cycle so they pulse for exactly
            // one cycle; data registers are left unassigned and hold.
            r_reg_wr_vld <= 1'b0;
            r_load_op    <= 1'b0;
            r_mem_err    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (ex_vld) begin
                        if (ex_load || ex_store) begin
                            // Load wins when both flags are set.
                            r_state   <= ST_REQ;
                            r_dm_req  <= 1'b1;
                            r_dm_we   <= !ex_load;
                            r_dm_addr <= ex_addr;
                            r_ld_dst  <= ex_dst;
                            if (!ex_load) begin
                                r_dm_wdata <= ex_sdata;
                            end
                        end else begin
                            r_reg_wr_vld <= 1'b1;
                            r_rslt       <= ex_rslt;
                            r_dst_o      <= ex_dst;
                        end
                    end
                end

                ST_REQ: begin
                    // Ack is checked first so a same-cycle ack beats the timeout.
                    if (dm.dm_ack) begin
                        r_dm_req <= 1'b0;
                        if (r_dm_we) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state      <= ST_WB;
                            r_reg_wr_vld <= 1'b1;
                            r_load_op    <= 1'b1;
                            r_dst        <= r_ld_dst;
                            r_dmdataout  <= dm.dm_rdata;
                        end
                    end else if (w_expire) begin
                        r_dm_req  <= 1'b0;
                        r_mem_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end

                ST_WB: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ex_stall    = (r_state != ST_IDLE);
    assign dm.dm_req   = r_dm_req;
    assign dm.dm_we    = r_dm_we;
    assign dm.dm_addr  = r_dm_addr;
    assign dm.dm_wdata = r_dm_wdata;
    assign reg_wr_vld  = r_reg_wr_vld;
    assign load_op     = r_load_op;
    assign rslt        = r_rslt;
    assign dst_o       = r_dst_o;
    assign dst         = r_dst;
    assign dmdataout   = r_dmdataout;
    assign mem_err     = r_mem_err;

endmodule

// File: tb/tb_risc_wb_ctrl.sv
// Scoreboard bench for risc_wb_ctrl: the driver predicts register writes,
// memory requests, timeouts and stall lengths; a negedge monitor compares.
module tb_risc_wb_ctrl;

    localparam int DW      = 8;
    localparam int AW      = 8;
    localparam int RW      = 3;
    localparam int TIMEOUT = 15;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_BOTH  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ex_vld = 1'b0;
    logic          ex_load = 1'b0;
    logic          ex_store = 1'b0;
    logic [DW-1:0] ex_rslt = '0;
    logic [RW-1:0] ex_dst = '0;
    logic [AW-1:0] ex_addr = '0;
    logic [DW-1:0] ex_sdata = '0;
    logic          ex_stall;
    logic          reg_wr_vld;
    logic          load_op;
    logic [DW-1:0] rslt;
    logic [RW-1:0] dst_o;
    logic [RW-1:0] dst;
    logic [DW-1:0] dmdataout;
    logic          mem_err;

    risc_wb_ctrl_if #(.AW(AW), .DW(DW)) dm_bus ();

    risc_wb_ctrl #(.DW(DW), .AW(AW), .RW(RW), .TIMEOUT(TIMEOUT), .TW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_vld     (ex_vld),
        .ex_load    (ex_load),
        .ex_store   (ex_store),
        .ex_rslt    (ex_rslt),
        .ex_dst     (ex_dst),
        .ex_addr    (ex_addr),
        .ex_sdata   (ex_sdata),
        .ex_stall   (ex_stall),
        .dm         (dm_bus),
        .reg_wr_vld (reg_wr_vld),
        .load_op    (load_op),
        .rslt       (rslt),
        .dst_o      (dst_o),
        .dst        (dst),
        .dmdataout  (dmdataout),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          ld;
        logic [RW-1:0] idx;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    wr_t  wq[$];
    req_t rq[$];
    int   err_pending = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    logic          prev_req = 1'b0;
    logic          prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_wr_vld) begin
                check("write_pending", 32'(wq.size() > 0), 32'd1);
                if (wq.size() > 0) begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wb_load_op", 32'(load_op), 32'(e.ld));
                    if (e.ld) begin
                        check("wb_dst", 32'(dst), 32'(e.idx));
                        check("wb_dmdataout", 32'(dmdataout), 32'(e.data));
                    end else begin
                        check("wb_dst_o", 32'(dst_o), 32'(e.idx));
                        check("wb_rslt", 32'(rslt), 32'(e.data));
                    end
                end
            end else begin
                check("load_op_without_write", 32'(load_op), 32'd0);
            end
            if (mem_err) begin
                check("mem_err_pending", 32'(err_pending > 0), 32'd1);
                if (err_pending > 0) err_pending--;
            end
            if (dm_bus.dm_req && !prev_req) begin
                check("req_pending", 32'(rq.size() > 0), 32'd1);
                if (rq.size() > 0) begin
                    req_t r;
                    r = rq.pop_front();
                    check("req_we", 32'(dm_bus.dm_we), 32'(r.we));
                    check("req_addr", 32'(dm_bus.dm_addr), 32'(r.addr));
                    if (r.we) check("req_wdata", 32'(dm_bus.dm_wdata), 32'(r.wdata));
                end
            end else if (dm_bus.dm_req) begin
                check("req_addr_stable", 32'(dm_bus.dm_addr), 32'(prev_addr));
                check("req_we_stable", 32'(dm_bus.dm_we), 32'(prev_we));
            end
        end
        prev_req  = rst_n && dm_bus.dm_req;
        prev_we   = dm_bus.dm_we;
        prev_addr = dm_bus.dm_addr;
    end

    // Issue one instruction (called #1 after a rising edge with the DUT idle)
    // and, for memory ops, play the memory: ack on REQ cycle `lat`
    // (1..TIMEOUT), or never when lat is outside that range.
    task automatic run_op(input int kind, input logic [DW-1:0] rslt_v,
                          input logic [RW-1:0] dst_v, input logic [AW-1:0] addr_v,
                          input logic [DW-1:0] sdata_v, input int lat,
                          input logic [DW-1:0] rdata_v);
        bit is_ld;
        bit acked;
        int exp_stall;
        int n;
        int reqc;
        is_ld    = (kind == K_LOAD) || (kind == K_BOTH);
        acked    = (lat >= 1) && (lat <= TIMEOUT);
        ex_vld   = 1'b1;
        ex_load  = is_ld;
        ex_store = (kind == K_STORE) || (kind == K_BOTH);
        ex_rslt  = rslt_v;
        ex_dst   = dst_v;
        ex_addr  = addr_v;
        ex_sdata = sdata_v;
        if (kind == K_ALU) begin
            wq.push_back('{ld: 1'b0, idx: dst_v, data: rslt_v});
            exp_stall = 0;
        end else begin
            rq.push_back('{we: !is_ld, addr: addr_v, wdata: sdata_v});
            if (!acked) begin
                err_pending++;
                exp_stall = TIMEOUT;
            end else if (is_ld) begin
                wq.push_back('{ld: 1'b1, idx: dst_v, data: rdata_v});
                exp_stall = lat + 1;
            end else begin
                exp_stall = lat;
            end
        end
        @(posedge clk);
        #1;
        ex_vld   = 1'b0;
        ex_load  = 1'($urandom);
        ex_store = 1'($urandom);
        ex_rslt  = DW'($urandom);
        ex_addr  = AW'($urandom);
        if (kind == K_ALU) begin
            check("alu_no_stall", 32'(ex_stall), 32'd0);
        end else begin
            n = 0;
            reqc = 0;
            while (ex_stall && n < 40) begin
                n++;
                if (dm_bus.dm_req) begin
                    reqc++;
                    dm_bus.dm_ack = (reqc == lat);
                end
                dm_bus.dm_rdata = dm_bus.dm_ack ? rdata_v : DW'($urandom);
                @(posedge clk);
                #1;
                dm_bus.dm_ack = 1'b0;
            end
            check("stall_cycles", 32'(n), 32'(exp_stall));
        end
    endtask

    initial begin
        dm_bus.dm_ack   = 1'b0;
        dm_bus.dm_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ex_stall", 32'(ex_stall), 32'd0);
        check("rst_dm_req", 32'(dm_bus.dm_req), 32'd0);
        check("rst_dm_we", 32'(dm_bus.dm_we), 32'd0);
        check("rst_dm_addr", 32'(dm_bus.dm_addr), 32'd0);
        check("rst_reg_wr_vld", 32'(reg_wr_vld), 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_rslt", 32'(rslt), 32'd0);
        check("rst_dmdataout", 32'(dmdataout), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        run_op(K_ALU,   8'h3C, 3'd3, 8'h00, 8'h00, 0,  8'h00);
        run_op(K_ALU,   8'hA5, 3'd7, 8'h00, 8'h00, 0,  8'h00);
        run_op(K_LOAD,  8'h00, 3'd5, 8'h40, 8'h00, 2,  8'h77);
        run_op(K_STORE, 8'h00, 3'd1, 8'h10, 8'hEE, 1,  8'h00);
        run_op(K_LOAD,  8'h00, 3'd2, 8'h55, 8'h00, 0,  8'h00);
        run_op(K_LOAD,  8'h00, 3'd6, 8'h56, 8'h00, 15, 8'h9B);
        run_op(K_STORE, 8'h00, 3'd0, 8'h57, 8'h33, 0,  8'h00);
        run_op(K_BOTH,  8'h00, 3'd0, 8'h22, 8'h5A, 1,  8'h01);

        // Reset in the middle of an outstanding load.
        ex_vld  = 1'b1;
        ex_load = 1'b1;
        ex_store = 1'b0;
        ex_addr = 8'h80;
        ex_dst  = 3'd4;
        rq.push_back('{we: 1'b0, addr: 8'h80, wdata: '0});
        @(posedge clk);
        #1;
        ex_vld = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_dm_req", 32'(dm_bus.dm_req), 32'd0);
        check("midrst_ex_stall", 32'(ex_stall), 32'd0);
        check("midrst_reg_wr_vld", 32'(reg_wr_vld), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(K_ALU, 8'hC3, 3'd2, 8'h00, 8'h00, 0, 8'h00);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            int k;
            int lat;
            int sel;
            k   = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       lat = sel + 1;
            else if (sel == 6) lat = TIMEOUT;
            else if (sel == 7) lat = TIMEOUT - 1;
            else               lat = 0;
            run_op(k, DW'($urandom), RW'($urandom), AW'($urandom),
                   DW'($urandom), lat, DW'($urandom));
        end

        repeat (4) @(posedge clk);
        #1;
        check("end_writes_drained", 32'(wq.size()), 32'd0);
        check("end_reqs_drained", 32'(rq.size()), 32'd0);
        check("end_errs_drained", 32'(err_pending), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
